result_mailbox: RTL and testbench

- Buffers 24-bit results from a hardware accelerator (e.g. the move/eval engine) and presents the head entry, plus status, as a 32-bit word.
- That word drives the in_port of the NIOS read-only PIO input stage.
- Software consumes an entry by flipping a toggle bit driven from an output PIO, which pops the FIFO.
- Single clock domain with the PIOs; no CDC inside.

---
 rtl/result_mailbox_if.sv | 20 ++
 rtl/result_mailbox.sv | 88 ++++++++
 tb/tb_result_mailbox.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/result_mailbox_if.sv
// Producer/PIO-facing signal bundle for the result mailbox.
// The slave modport is the mailbox; the master side is the accelerator plus the PIOs.
interface result_mailbox_if;
   logic        push_valid;
   logic [23:0] push_data;
   logic        push_ready;
   logic [1:0]  ctrl;
   logic [31:0] out_word;
   logic        irq_pending;

   modport master (
      output push_valid, push_data, ctrl,
      input  push_ready, out_word, irq_pending
   );

   modport slave (
      input  push_valid, push_data, ctrl,
      output push_ready, out_word, irq_pending
   );
endinterface

// File: rtl/result_mailbox.sv
// FIFO of accelerator results exposed to software as one registered 32-bit status/data word.
// Software pops by toggling ctrl[0]; ctrl[1] held high clears the sticky overflow flag.
module result_mailbox #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 24
) (
   input logic             clk,
   input logic             reset_n,
   result_mailbox_if.slave mb
);
   localparam int         PTR_W = $clog2(DEPTH);
   localparam logic [3:0] FULL  = 4'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]        level_q, level_d;
   logic [1:0]        seq_q, seq_d;
   logic              overflow_q, overflow_d;
   logic              ack_q, ack_d;
   logic [31:0]       out_word_q, out_word_d;
   logic              push_ready_q, push_ready_d;
   logic              irq_q, irq_d;

   logic              pop_evt, pop_do, push_acc, push_drop;
   logic [DATA_W-1:0] head_d;

   always_comb begin
      pop_evt   = mb.ctrl[0] ^ ack_q;
      pop_do    = pop_evt && (level_q != 4'd0);
      // A same-cycle pop frees the slot, so push while full still lands.
      push_acc  = mb.push_valid && ((level_q != FULL) || pop_do);
      push_drop = mb.push_valid && !push_acc;

      ack_d    = mb.ctrl[0];
      wr_ptr_d = wr_ptr_q + PTR_W'(push_acc);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_do);
      seq_d    = seq_q + 2'(pop_do);
      level_d  = level_q + 4'(push_acc) - 4'(pop_do);

      overflow_d = overflow_q;
      if (mb.ctrl[1]) overflow_d = 1'b0;
      if (push_drop)  overflow_d = 1'b1;

      // The entry being written this cycle becomes head when nothing older remains.
      head_d = '0;
      if (level_d != 4'd0) begin
         if (push_acc && (rd_ptr_d == wr_ptr_q)) head_d = mb.push_data;
         else                                    head_d = mem_q[rd_ptr_d];
      end

      out_word_d   = {(level_d != 4'd0), overflow_d, seq_d, level_d, head_d};
      push_ready_d = (level_d != FULL);
      irq_d        = (level_d != 4'd0);
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= mb.push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         seq_q        <= '0;
         overflow_q   <= 1'b0;
         ack_q        <= 1'b0;
         out_word_q   <= '0;
         push_ready_q <= 1'b1;
         irq_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         seq_q        <= seq_d;
         overflow_q   <= overflow_d;
         ack_q        <= ack_d;
         out_word_q   <= out_word_d;
         push_ready_q <= push_ready_d;
         irq_q        <= irq_d;
      end
   end

   assign mb.out_word    = out_word_q;
   assign mb.push_ready  = push_ready_q;
   assign mb.irq_pending = irq_q;
endmodule

// File: tb/tb_result_mailbox.sv
// Bench for result_mailbox: directed vector table, hand-written full/overflow and
// reset sequences, then randomized traffic against a queue-based reference model.
module tb_result_mailbox;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   result_mailbox_if mb();

   result_mailbox #(.DEPTH(DEPTH), .DATA_W(24)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mb      (mb)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue plus counters, evaluated once per clock edge.
   logic [23:0] mq[$];
   int          m_seq;
   bit          m_ovf;
   bit          m_prev0;

   function automatic void model_reset();
      mq.delete();
      m_seq   = 0;
      m_ovf   = 1'b0;
      m_prev0 = 1'b0;
   endfunction

   function automatic void model_edge(input bit pv, input logic [23:0] pd, input logic [1:0] c);
      bit evt;
      evt     = (c[0] != m_prev0);
      m_prev0 = c[0];
      if (evt && mq.size() > 0) begin
         void'(mq.pop_front());
         m_seq = (m_seq + 1) % 4;
      end
      if (c[1]) m_ovf = 1'b0;
      if (pv) begin
         if (mq.size() < DEPTH) mq.push_back(pd);
         else                   m_ovf = 1'b1;
      end
   endfunction

   function automatic logic [31:0] model_word();
      logic [31:0] w;
      int sz;
      sz       = mq.size();
      w        = '0;
      w[31]    = (sz != 0);
      w[30]    = m_ovf;
      w[29:28] = m_seq[1:0];
      w[27:24] = sz[3:0];
      if (sz != 0) w[23:0] = mq[0];
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [31:0] w, input bit rdy);
      chk({name, ".word"}, mb.out_word, w);
      chk({name, ".ready"}, 32'(mb.push_ready), 32'(rdy));
      chk({name, ".irq"}, 32'(mb.irq_pending), 32'(w[31]));
   endtask

   // Drive inputs away from the edge, clock once, sample 1 time unit later.
   task automatic step(input bit pv, input logic [23:0] pd, input logic [1:0] c);
      mb.push_valid = pv;
      mb.push_data  = pd;
      mb.ctrl       = c;
      @(posedge clk);
      model_edge(pv, pd, c);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] c);
      mb.push_valid = 1'b0;
      mb.push_data  = '0;
      mb.ctrl       = c;
      reset_n       = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit          rst;
      bit          pv;
      logic [23:0] pd;
      logic [1:0]  c;
      logic [31:0] w;
      bit          rdy;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [1:0]  c0;
      logic [31:0] w;
      int          pct;

      mb.push_valid = 1'b0;
      mb.push_data  = '0;
      mb.ctrl       = 2'b00;
      model_reset();

      // FIFO order and seq across three spaced pops
      tbl.push_back('{1'b1, 1'b0, 24'h0,      2'b00, 32'h0000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 24'h000001, 2'b00, 32'h8100_0001, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 24'h000002, 2'b00, 32'h8200_0001, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 24'h000003, 2'b00, 32'h8300_0001, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b01, 32'h9200_0002, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b01, 32'h9200_0002, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b01, 32'h9200_0002, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b00, 32'hA100_0003, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b00, 32'hA100_0003, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b00, 32'hA100_0003, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b01, 32'h3000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b00, 32'h3000_0000, 1'b1});
      // pop on empty (including ctrl[0]=1 across reset), then same-cycle push
      tbl.push_back('{1'b1, 1'b0, 24'h0,      2'b01, 32'h0000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b01, 32'h0000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 24'h0,      2'b00, 32'h0000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 24'h000007, 2'b01, 32'h8100_0007, 1'b1});
      // first push after reset
      tbl.push_back('{1'b1, 1'b0, 24'h0,      2'b00, 32'h0000_0000, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 24'h00ABCD, 2'b00, 32'h8100_ABCD, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset(tbl[i].c);
         else            step(tbl[i].pv, tbl[i].pd, tbl[i].c);
         chk_all($sformatf("vec%0d", i), tbl[i].w, tbl[i].rdy);
      end

      // Fill to full, drop, overflow clear, push+pop while full, drain
      do_reset(2'b00);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 24'h10 + 24'(i), 2'b00);
         chk_all($sformatf("fill%0d", i), 32'h8000_0010 | (32'(i + 1) << 24), (i != DEPTH - 1));
      end
      step(1'b1, 24'h0000FF, 2'b00);
      chk_all("drop", 32'hC800_0010, 1'b0);
      step(1'b1, 24'h0000FE, 2'b10);
      chk_all("drop_beats_clear", 32'hC800_0010, 1'b0);
      step(1'b0, 24'h0, 2'b10);
      chk_all("ovf_clear", 32'h8800_0010, 1'b0);
      step(1'b0, 24'h0, 2'b00);
      chk_all("idle_full", 32'h8800_0010, 1'b0);
      step(1'b1, 24'h000099, 2'b01);
      chk_all("push_pop_full", 32'h9800_0011, 1'b0);
      c0 = 2'b01;
      for (int k = 1; k <= DEPTH; k++) begin
         c0[0] = ~c0[0];
         step(1'b0, 24'h0, c0);
         w = (32'((1 + k) % 4) << 28);
         if (k < DEPTH) w = w | 32'h8000_0000 | (32'(DEPTH - k) << 24);
         if (k <= 6) w = w | (32'h11 + 32'(k));
         else if (k == 7) w = w | 32'h99;
         chk_all($sformatf("drain%0d", k), w, 1'b1);
      end

      // Asynchronous reset mid-stream with ctrl[0] held high
      do_reset(2'b00);
      step(1'b1, 24'h000A01, 2'b00);
      step(1'b1, 24'h000A02, 2'b00);
      step(1'b1, 24'h000A03, 2'b00);
      chk_all("pre_rst", 32'h8300_0A01, 1'b1);
      @(negedge clk);
      mb.push_valid = 1'b0;
      mb.ctrl       = 2'b01;
      reset_n       = 1'b0;
      #1;
      chk_all("async_rst", 32'h0000_0000, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 24'h0, 2'b01);
         chk_all($sformatf("post_rst%0d", i), 32'h0000_0000, 1'b1);
      end

      // Randomized traffic with shifting push/pop pressure
      do_reset(2'b00);
      c0  = 2'b00;
      pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) pct = $urandom_range(10, 95);
         c0[0] = c0[0] ^ ($urandom_range(0, 99) >= pct);
         c0[1] = ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 99) < pct, 24'($urandom), c0);
         chk("rnd.word", mb.out_word, model_word());
         chk("rnd.ready", 32'(mb.push_ready), 32'(mq.size() != DEPTH));
         chk("rnd.irq", 32'(mb.irq_pending), 32'(mq.size() != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
